video_ctrl_regs: RTL

VIDEO_CTRL_REGS -- requirements
Module: video_ctrl_regs

---
 rtl/ogege_regs_pkg.sv | 28 ++
 rtl/rise_detect.sv | 29 ++
 rtl/video_ctrl_regs.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ogege_regs_pkg.sv
// ogege_regs_pkg
//   Shared constants for the video control register block: bus and field widths,
//   register byte offsets and the default colour reset values.
//   No ports.
package ogege_regs_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned COLOR_W = 12;
    localparam int unsigned FRAME_W = 16;
    // Width of the upper colour nibble carried by the *_HI registers.
    localparam int unsigned HI_W    = COLOR_W - DATA_W;

    localparam logic [COLOR_W-1:0] RST_FG_DEFAULT = 12'hFFF;
    localparam logic [COLOR_W-1:0] RST_BG_DEFAULT = 12'h000;

    localparam logic [ADDR_W-1:0] ADDR_FG_LO    = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_FG_HI    = 4'h1;
    localparam logic [ADDR_W-1:0] ADDR_BG_LO    = 4'h2;
    localparam logic [ADDR_W-1:0] ADDR_BG_HI    = 4'h3;
    localparam logic [ADDR_W-1:0] ADDR_SCROLL   = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 4'h5;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = 4'h6;
    localparam logic [ADDR_W-1:0] ADDR_FRAME_LO = 4'h7;
    localparam logic [ADDR_W-1:0] ADDR_FRAME_HI = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH  = 4'h9;

endpackage

// File: rtl/rise_detect.sv
// rise_detect
//   Single-bit rising-edge detector with a configurable reset value for the
//   delayed copy, so a level already high at reset release can be masked.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   i_sig  : level to watch (synchronous to i_clk)
//   o_rise : high for the cycle in which i_sig is 1 and was 0 on the previous edge
module rise_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise
);

    logic sig_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~sig_q;

endmodule

// File: rtl/video_ctrl_regs.sv
// video_ctrl_regs
//   CPU-visible control/status registers for the video core: atomic colour
//   updates, vertical scroll, VBL flag with interrupt, frame counter with a
//   latched high byte, and a scratch byte.
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_cs, i_stb, i_we       : chip select, bus strobe (edge-started), write enable
//   i_addr, i_data          : register offset, write data
//   i_vsync_evt             : frame-start level from the timing core
//   o_data, o_data_ready    : registered read data, one-cycle read-complete pulse
//   o_fg_color, o_bg_color  : committed colours
//   o_scroll_y              : vertical text scroll in pixel rows
//   o_irq                   : level interrupt (VBL & IRQ_EN)
module video_ctrl_regs
    import ogege_regs_pkg::*;
#(
    parameter logic [COLOR_W-1:0] RST_FG = RST_FG_DEFAULT,
    parameter logic [COLOR_W-1:0] RST_BG = RST_BG_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cs,
    input  logic               i_stb,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_vsync_evt,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_data_ready,
    output logic [COLOR_W-1:0] o_fg_color,
    output logic [COLOR_W-1:0] o_bg_color,
    output logic [DATA_W-1:0]  o_scroll_y,
    output logic               o_irq
);

    logic stb_rise;
    logic vsync_rise;
    logic access;
    logic wr_en;
    logic rd_en;

    logic [DATA_W-1:0]  fg_lo_q, fg_lo_d;
    logic [DATA_W-1:0]  bg_lo_q, bg_lo_d;
    logic [COLOR_W-1:0] fg_q, fg_d;
    logic [COLOR_W-1:0] bg_q, bg_d;
    logic [DATA_W-1:0]  scroll_q, scroll_d;
    logic               vbl_q, vbl_d;
    logic               irq_en_q, irq_en_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [DATA_W-1:0]  shadow_q, shadow_d;
    logic [DATA_W-1:0]  scratch_q, scratch_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rready_q, rready_d;
    logic               irq_q, irq_d;
    logic [DATA_W-1:0]  rd_mux;

    // Strobe history resets high so a strobe held across reset release is not an access.
    rise_detect #(
        .RST_VAL (1'b1)
    ) u_stb_rise (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_stb),
        .o_rise (stb_rise)
    );

    rise_detect #(
        .RST_VAL (1'b0)
    ) u_vsync_rise (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_vsync_evt),
        .o_rise (vsync_rise)
    );

    assign access = i_cs & stb_rise & ~i_rst;
    assign wr_en  = access & i_we;
    assign rd_en  = access & ~i_we;

    // Read multiplexer; unused bits and reserved offsets read as zero.
    always_comb begin
        rd_mux = '0;
        case (i_addr)
            ADDR_FG_LO:    rd_mux = fg_lo_q;
            ADDR_FG_HI:    rd_mux = {{(DATA_W-HI_W){1'b0}}, fg_q[COLOR_W-1:DATA_W]};
            ADDR_BG_LO:    rd_mux = bg_lo_q;
            ADDR_BG_HI:    rd_mux = {{(DATA_W-HI_W){1'b0}}, bg_q[COLOR_W-1:DATA_W]};
            ADDR_SCROLL:   rd_mux = scroll_q;
            ADDR_STATUS:   rd_mux = {{(DATA_W-1){1'b0}}, vbl_q};
            ADDR_IRQ_EN:   rd_mux = {{(DATA_W-1){1'b0}}, irq_en_q};
            ADDR_FRAME_LO: rd_mux = frame_q[DATA_W-1:0];
            ADDR_FRAME_HI: rd_mux = shadow_q;
            ADDR_SCRATCH:  rd_mux = scratch_q;
            default:       rd_mux = '0;
        endcase
    end

    always_comb begin
        fg_lo_d   = fg_lo_q;
        bg_lo_d   = bg_lo_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        scroll_d  = scroll_q;
        vbl_d     = vbl_q;
        irq_en_d  = irq_en_q;
        frame_d   = frame_q;
        shadow_d  = shadow_q;
        scratch_d = scratch_q;
        rdata_d   = rdata_q;
        rready_d  = rd_en;

        if (wr_en) begin
            case (i_addr)
                ADDR_FG_LO:   fg_lo_d = i_data;
                // HI write commits the staged low byte together with the new nibble.
                ADDR_FG_HI:   fg_d = {i_data[HI_W-1:0], fg_lo_q};
                ADDR_BG_LO:   bg_lo_d = i_data;
                ADDR_BG_HI:   bg_d = {i_data[HI_W-1:0], bg_lo_q};
                ADDR_SCROLL:  scroll_d = i_data;
                ADDR_STATUS:  begin
                    if (i_data[0]) begin
                        vbl_d = 1'b0;
                    end
                end
                ADDR_IRQ_EN:  irq_en_d = i_data[0];
                ADDR_SCRATCH: scratch_d = i_data;
                default:      ;
            endcase
        end

        // Applied after the write decode so a same-cycle set beats W1C.
        if (vsync_rise) begin
            vbl_d   = 1'b1;
            frame_d = frame_q + FRAME_W'(1);
        end

        if (rd_en) begin
            rdata_d = rd_mux;
            // Freeze the high byte so a LO-then-HI read pair is coherent.
            if (i_addr == ADDR_FRAME_LO) begin
                shadow_d = frame_q[FRAME_W-1:DATA_W];
            end
        end

        irq_d = vbl_d & irq_en_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fg_lo_q   <= '0;
            bg_lo_q   <= '0;
            fg_q      <= RST_FG;
            bg_q      <= RST_BG;
            scroll_q  <= '0;
            vbl_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            frame_q   <= '0;
            shadow_q  <= '0;
            scratch_q <= '0;
            rdata_q   <= '0;
            rready_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            fg_lo_q   <= fg_lo_d;
            bg_lo_q   <= bg_lo_d;
            fg_q      <= fg_d;
            bg_q      <= bg_d;
            scroll_q  <= scroll_d;
            vbl_q     <= vbl_d;
            irq_en_q  <= irq_en_d;
            frame_q   <= frame_d;
            shadow_q  <= shadow_d;
            scratch_q <= scratch_d;
            rdata_q   <= rdata_d;
            rready_q  <= rready_d;
            irq_q     <= irq_d;
        end
    end

    assign o_data       = rdata_q;
    assign o_data_ready = rready_q;
    assign o_fg_color   = fg_q;
    assign o_bg_color   = bg_q;
    assign o_scroll_y   = scroll_q;
    assign o_irq        = irq_q;

endmodule
